// File: rtl/dht11_pkg.sv
// Shared DHT11 bus definitions: emulator state encoding, phase lengths in microseconds
// and the frame checksum, also used by the host controller.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_RESP_WAIT,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW
    } dht11_state_e;

    localparam int unsigned RESP_LOW_US  = 80;
    localparam int unsigned RESP_HIGH_US = 80;
    localparam int unsigned BIT_LOW_US   = 50;
    localparam int unsigned BIT0_HIGH_US = 26;
    localparam int unsigned BIT1_HIGH_US = 70;
    localparam int unsigned END_LOW_US   = 50;
    localparam int unsigned FRAME_BITS   = 40;

    function automatic logic [7:0] dht11_checksum(input logic [7:0] hum_int,
                                                  input logic [7:0] hum_frac,
                                                  input logic [7:0] temp_int,
                                                  input logic [7:0] temp_frac);
        return hum_int + hum_frac + temp_int + temp_frac;
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Microsecond prescaler: one-cycle tick every CYCLES_PER_US clocks, restartable so that
// each emulator phase begins on a fresh microsecond boundary.
module dht11_us_tick #(
    parameter int unsigned CYCLES_PER_US = 50
) (
    input  logic i_Clock,
    input  logic i_Rst,
    input  logic i_Restart,
    output logic o_Tick
);
    localparam int unsigned CNT_W = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_US - 1);

    logic [CNT_W-1:0] cnt_q;

    assign o_Tick = (cnt_q == LAST);

    always_ff @(posedge i_Clock) begin
        if (i_Rst || i_Restart || o_Tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor emulator: answers a host start pulse with the response preamble and a
// 40-bit frame. Define DHT11_EMU_CRC_ERR_EN to add i_Crc_Corrupt (checksum LSB flip).
module dht11_sensor_emu
    import dht11_pkg::*;
#(
    parameter int unsigned CYCLES_PER_US = 50,
    parameter int unsigned START_MIN_US  = 1000,
    parameter int unsigned RESP_WAIT_US  = 30
) (
    input  logic       i_Clock,
    input  logic       i_Rst,
    input  logic       i_En,
    input  logic       i_Dht_Line,
    output logic       o_Dht_Pull_Low,
    input  logic [7:0] i_Hum_Int,
    input  logic [7:0] i_Hum_Float,
    input  logic [7:0] i_Temp_Int,
    input  logic [7:0] i_Temp_Float,
`ifdef DHT11_EMU_CRC_ERR_EN
    input  logic       i_Crc_Corrupt,
`endif
    output logic [7:0] o_Crc,
    output logic       o_Busy,
    output logic       o_Frame_Done,
    output logic       o_Glitch
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    dht11_state_e state_q, state_d;
    logic         line_p0, line_p1;
    logic [15:0]  us_cnt_q;
    logic [15:0]  phase_us;
    logic [5:0]   bit_idx_q;
    logic [39:0]  shreg_q;
    logic [7:0]   frame_crc;
    logic         tick, restart, phase_done, start_ok, last_bit;
    logic         accept, pull_d, busy_d, done_d, glitch_d;

    // Stage p0/p1: two-flop synchroniser; the idle bus level is high
    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            line_p0 <= 1'b1;
            line_p1 <= 1'b1;
        end else begin
            line_p0 <= i_Dht_Line;
            line_p1 <= line_p0;
        end
    end

    assign restart = (state_d != state_q);

    dht11_us_tick #(.CYCLES_PER_US(CYCLES_PER_US)) u_us_tick (
        .i_Clock  (i_Clock),
        .i_Rst    (i_Rst),
        .i_Restart(restart),
        .o_Tick   (tick)
    );

    always_comb begin
        phase_us = 16'd0;
        case (state_q)
            ST_RESP_WAIT: phase_us = 16'(RESP_WAIT_US);
            ST_RESP_LOW:  phase_us = 16'(RESP_LOW_US);
            ST_RESP_HIGH: phase_us = 16'(RESP_HIGH_US);
            ST_BIT_LOW:   phase_us = 16'(BIT_LOW_US);
            ST_BIT_HIGH:  phase_us = shreg_q[39] ? 16'(BIT1_HIGH_US) : 16'(BIT0_HIGH_US);
            ST_END_LOW:   phase_us = 16'(END_LOW_US);
            default:      phase_us = 16'd0;
        endcase
    end

    assign phase_done = tick && (us_cnt_q == phase_us - 16'd1);
    assign start_ok   = (us_cnt_q >= 16'(START_MIN_US));
    assign last_bit   = (bit_idx_q == 6'(FRAME_BITS - 1));

`ifdef DHT11_EMU_CRC_ERR_EN
    assign frame_crc = dht11_checksum(i_Hum_Int, i_Hum_Float, i_Temp_Int, i_Temp_Float)
                       ^ {7'd0, i_Crc_Corrupt};
`else
    assign frame_crc = dht11_checksum(i_Hum_Int, i_Hum_Float, i_Temp_Int, i_Temp_Float);
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!i_En) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      if (!line_p1)   state_d = ST_START_LOW;
                ST_START_LOW: if (line_p1)    state_d = start_ok ? ST_RESP_WAIT : ST_IDLE;
                ST_RESP_WAIT: if (phase_done) state_d = ST_RESP_LOW;
                ST_RESP_LOW:  if (phase_done) state_d = ST_RESP_HIGH;
                ST_RESP_HIGH: if (phase_done) state_d = ST_BIT_LOW;
                ST_BIT_LOW:   if (phase_done) state_d = ST_BIT_HIGH;
                ST_BIT_HIGH:  if (phase_done) state_d = last_bit ? ST_END_LOW : ST_BIT_LOW;
                ST_END_LOW:   if (phase_done) state_d = ST_IDLE;
                default:                      state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered pin moves with the state
    always_comb begin
        pull_d   = (state_d == ST_RESP_LOW) || (state_d == ST_BIT_LOW) || (state_d == ST_END_LOW);
        busy_d   = (state_d != ST_IDLE) && (state_d != ST_START_LOW);
        accept   = 1'b0;
        glitch_d = 1'b0;
        done_d   = 1'b0;
        if (i_En) begin
            accept   = (state_q == ST_START_LOW) && line_p1 && start_ok;
            glitch_d = (state_q == ST_START_LOW) && line_p1 && !start_ok;
            done_d   = (state_q == ST_END_LOW) && phase_done;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            o_Dht_Pull_Low <= 1'b0;
            o_Busy         <= 1'b0;
            o_Frame_Done   <= 1'b0;
            o_Glitch       <= 1'b0;
            o_Crc          <= 8'h00;
        end else begin
            o_Dht_Pull_Low <= pull_d;
            o_Busy         <= busy_d;
            o_Frame_Done   <= done_d;
            o_Glitch       <= glitch_d;
            if (accept) begin
                o_Crc <= frame_crc;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Rst || restart) begin
            us_cnt_q <= 16'd0;
        end else if (tick) begin
            us_cnt_q <= sat_inc16(us_cnt_q);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Rst || accept) begin
            bit_idx_q <= 6'd0;
        end else if ((state_q == ST_BIT_HIGH) && phase_done) begin
            bit_idx_q <= bit_idx_q + 6'd1;
        end
    end

    // Frame shift register is pure data: loaded at acceptance, MSB leaves first
    always_ff @(posedge i_Clock) begin
        if (accept) begin
            shreg_q <= {i_Hum_Int, i_Hum_Float, i_Temp_Int, i_Temp_Float, frame_crc};
        end else if ((state_q == ST_BIT_HIGH) && phase_done) begin
            shreg_q <= {shreg_q[38:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Bench for dht11_sensor_emu: a host model drives start pulses, a monitor decodes the
// pin waveform into frames and checks them against a scoreboard of expected frames.
module tb_dht11_sensor_emu;

    localparam int unsigned CPU       = 2;
    localparam int unsigned START_MIN = 100;
    localparam int unsigned RESP_WAIT = 30;
    localparam int unsigned HOST_LOW  = 180;

    typedef struct {
        logic [39:0] bits;
        logic [7:0]  crc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       host_pull = 1'b0;
    logic       corrupt = 1'b0;
    logic [7:0] hi = 8'h00, hf = 8'h00, ti = 8'h00, tf = 8'h00;
    logic       dut_line;
    logic       pull, busy, done, glitch;
    logic [7:0] crc;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0, glitch_cnt = 0, pull_cyc = 0, busy_cyc = 0;

    bit          m_act = 1'b0;
    logic        m_prev;
    int          m_run, m_seg, m_bad;
    logic [39:0] m_bits;

    assign dut_line = !(pull || host_pull);

    always #5 clk = ~clk;

    dht11_sensor_emu #(
        .CYCLES_PER_US(CPU),
        .START_MIN_US (START_MIN),
        .RESP_WAIT_US (RESP_WAIT)
    ) dut (
        .i_Clock       (clk),
        .i_Rst         (rst),
        .i_En          (en),
        .i_Dht_Line    (dut_line),
        .o_Dht_Pull_Low(pull),
        .i_Hum_Int     (hi),
        .i_Hum_Float   (hf),
        .i_Temp_Int    (ti),
        .i_Temp_Float  (tf),
`ifdef DHT11_EMU_CRC_ERR_EN
        .i_Crc_Corrupt (corrupt),
`endif
        .o_Crc         (crc),
        .o_Busy        (busy),
        .o_Frame_Done  (done),
        .o_Glitch      (glitch)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_start(input int us);
        host_pull = 1'b1;
        cyc(us * CPU);
        host_pull = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done === 1'b1)   done_cnt++;
        if (glitch === 1'b1) glitch_cnt++;
        if (pull === 1'b1)   pull_cyc++;
        if (busy === 1'b1)   busy_cyc++;
    end

    // Monitor: measure every pin segment from o_Busy rising and decode bit-high lengths
    always @(negedge clk) begin
        if (!m_act) begin
            if (busy === 1'b1) begin
                m_act  = 1'b1;
                m_prev = pull;
                m_run  = 1;
                m_seg  = 0;
                m_bad  = 0;
                m_bits = '0;
            end
        end else begin
            if (pull !== m_prev) begin
                if (m_seg == 0) begin
                    if (m_run != RESP_WAIT * CPU) m_bad++;
                end else if (m_seg <= 2) begin
                    if (m_run != 80 * CPU) m_bad++;
                end else if (m_seg <= 82) begin
                    if (((m_seg - 3) % 2) == 0) begin
                        if (m_run != 50 * CPU) m_bad++;
                    end else if (m_run == 70 * CPU) begin
                        m_bits = {m_bits[38:0], 1'b1};
                    end else begin
                        m_bits = {m_bits[38:0], 1'b0};
                        if (m_run != 26 * CPU) m_bad++;
                    end
                end else if (m_seg == 83) begin
                    if (m_run != 50 * CPU) m_bad++;
                end else begin
                    m_bad++;
                end
                m_seg++;
                m_prev = pull;
                m_run  = 1;
            end else begin
                m_run++;
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: got bits %010h, expected no frame", m_bits);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("frame_bits", m_bits, e.bits);
                    check("frame_segments", m_seg, 84);
                    check("frame_timing_errs", m_bad, 0);
                    check("crc_at_done", crc, e.crc);
                end
                m_act = 1'b0;
            end else if (busy !== 1'b1) begin
                m_act = 1'b0;
            end
        end
    end

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic [7:0] exp_crc,
                             input logic [7:0] exp_ck_byte);
        exp_t e;
        int   dly, done0;
        bit   got_busy, got_pull, got_idle;
        hi = a; hf = b; ti = c; tf = d;
        e.bits = {a, b, c, d, exp_ck_byte};
        e.crc  = exp_crc;
        exp_q.push_back(e);
        done0 = done_cnt;
        host_start(HOST_LOW);
        dly = 0; got_busy = 0; got_pull = 0;
        for (int i = 0; i < 200 && !got_pull; i++) begin
            @(posedge clk); #1;
            dly++;
            if (busy && !got_busy) begin
                got_busy = 1;
                check("crc_at_busy", crc, exp_crc);
                hi = 8'hA5; hf = 8'h5A; ti = 8'hFF; tf = 8'h81;
            end
            if (pull) got_pull = 1;
        end
        n_cmp++;
        if (!got_pull || dly < 57 || dly > 63) begin
            n_bad++;
            $display("FAIL resp_delay: got %0d cycles (seen=%0d), expected 57..63", dly, got_pull);
        end
        got_idle = 0;
        for (int i = 0; i < 20000 && !got_idle; i++) begin
            @(negedge clk);
            if (!busy) got_idle = 1;
        end
        check("frame_end_reached", got_idle, 1'b1);
        cyc(5);
        check("frame_done_once", done_cnt - done0, 1);
    endtask

    initial begin
        int g0, p0, b0, d0, rises;
        bit last;
        cyc(3);
        check("rst_pull", pull, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_crc", crc, 8'h00);
        check("rst_done_glitch", {done, glitch}, 2'b00);
        rst = 1'b0;

        g0 = glitch_cnt; p0 = pull_cyc; b0 = busy_cyc;
        cyc(2000);
        check("idle_quiet", (glitch_cnt - g0) + (pull_cyc - p0) + (busy_cyc - b0), 0);

        run_frame(8'h37, 8'h00, 8'h19, 8'h00, 8'h50, 8'h50);

        g0 = glitch_cnt; p0 = pull_cyc; b0 = busy_cyc;
        host_start(50);
        cyc(50);
        check("short_glitch_count", glitch_cnt - g0, 1);
        check("short_no_pull", pull_cyc - p0, 0);
        check("short_no_busy", busy_cyc - b0, 0);

        hi = 8'h12; hf = 8'h34; ti = 8'h56; tf = 8'h78;
        d0 = done_cnt;
        host_start(HOST_LOW);
        rises = 0; last = 0;
        for (int i = 0; i < 20000 && rises < 14; i++) begin
            @(posedge clk); #1;
            if (pull && !last) rises++;
            last = pull;
        end
        check("abort_reached_bit12", rises, 14);
        cyc(10);
        check("abort_in_bit_low", pull, 1'b1);
        en = 1'b0;
        cyc(1);
        check("abort_pull_released", pull, 1'b0);
        check("abort_busy_low", busy, 1'b0);
        cyc(200);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_crc_hold", crc, 8'h14);
        en = 1'b1;
        cyc(5);

        run_frame(8'h3C, 8'h01, 8'h1E, 8'h05, 8'h60, 8'h60);

`ifdef DHT11_EMU_CRC_ERR_EN
        corrupt = 1'b1;
        run_frame(8'h37, 8'h00, 8'h19, 8'h00, 8'h51, 8'h51);
        corrupt = 1'b0;
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

endmodule
